// File: rtl/cgra_x_heep_pkg.sv
// Shared CGRA / X-HEEP integration constants: external crossbar sizing and
// the column index type used to tag outstanding OBI transactions.
package cgra_x_heep_pkg;

    localparam int EXT_XBAR_NMASTER     = 4;
    localparam int LOG_EXT_XBAR_NMASTER = (EXT_XBAR_NMASTER > 1) ? $clog2(EXT_XBAR_NMASTER) : 1;

    localparam int CGRA_COL_IDX_W = LOG_EXT_XBAR_NMASTER;
    typedef logic [CGRA_COL_IDX_W-1:0] cgra_col_idx_t;

endpackage

// File: rtl/cgra_col_id_fifo.sv
// Synchronous FIFO of column indices recording the owner of each outstanding
// OBI transaction; push and pop may coincide at any occupancy, including full.
module cgra_col_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cgra_col_obi_arbiter.sv
// Round-robin arbiter sharing one OBI master port among the CGRA columns;
// responses are routed back in order using the owner FIFO.
module cgra_col_obi_arbiter
    import cgra_x_heep_pkg::*;
#(
    parameter int N_MASTER        = EXT_XBAR_NMASTER,
    parameter int MAX_OUTSTANDING = 2,
    parameter int AW              = 32,
    parameter int DW              = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_MASTER-1:0]    col_req_i,
    output logic [N_MASTER-1:0]    col_gnt_o,
    input  logic [N_MASTER*AW-1:0] col_addr_i,
    input  logic [N_MASTER-1:0]    col_we_i,
    input  logic [N_MASTER*DW/8-1:0] col_be_i,
    input  logic [N_MASTER*DW-1:0] col_wdata_i,
    output logic [N_MASTER-1:0]    col_rvalid_o,
    output logic [DW-1:0]          col_rdata_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AW-1:0]          mem_addr_o,
    output logic                   mem_we_o,
    output logic [DW/8-1:0]        mem_be_o,
    output logic [DW-1:0]          mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DW-1:0]          mem_rdata_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int BW    = DW / 8;

    logic [IDX_W-1:0] prio_q, prio_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] sel, cand, fifo_head;
    logic             lock_hold, found;
    logic             fifo_full, fifo_empty;
    logic             pop, can_push, handshake;

    // A lock only survives while its column keeps requesting; a dropped
    // request falls back to the normal round-robin scan in the same cycle.
    always_comb begin
        lock_hold = lock_q & col_req_i[lock_idx_q];
        sel       = prio_q;
        cand      = prio_q;
        found     = 1'b0;
        if (lock_hold) begin
            sel = lock_idx_q;
        end else begin
            for (int i = 0; i < N_MASTER; i++) begin
                cand = IDX_W'((int'(prio_q) + i) % N_MASTER);
                if (!found && col_req_i[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    assign pop       = mem_rvalid_i & ~fifo_empty;
    assign can_push  = ~fifo_full | pop;
    assign mem_req_o = (|col_req_i) & can_push;
    assign handshake = mem_req_o & mem_gnt_i;

    assign mem_addr_o  = col_addr_i[int'(sel)*AW +: AW];
    assign mem_we_o    = col_we_i[sel];
    assign mem_be_o    = col_be_i[int'(sel)*BW +: BW];
    assign mem_wdata_o = col_wdata_i[int'(sel)*DW +: DW];

    assign col_rdata_o = mem_rdata_i;
    assign busy_o      = ~fifo_empty | mem_req_o;
    assign err_o       = err_q;

    always_comb begin
        col_gnt_o    = '0;
        col_rvalid_o = '0;
        if (handshake) begin
            col_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            col_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_hold;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (mem_rvalid_i & fifo_empty);
        if (handshake) begin
            prio_d = IDX_W'((int'(sel) + 1) % N_MASTER);
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    cgra_col_id_fifo #(
        .W     (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
